// File: rtl/lfsr_noise_array_pkg.sv
// noise_pkg: shared constants, state and mode encodings for the multi-lane noise source.
//   LFSR_POLY_MASK : Galois feedback mask for the right-shift 32-bit LFSR
//   DEFAULT_SEED   : base seed used when none is supplied or a zero seed is loaded
//   SEED_MIX       : golden-ratio constant that decorrelates the per-lane reset seeds
//   state_t        : sample FSM states
//   mode_t         : uniform / Gaussian mode encodings
package noise_pkg;

    localparam logic [31:0] LFSR_POLY_MASK = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED   = 32'hACE1_2345;
    localparam logic [31:0] SEED_MIX       = 32'h9E37_79B9;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
    typedef enum logic {NOISE_UNIFORM = 1'b0, NOISE_GAUSS = 1'b1} mode_t;

    // A lane whose mixed seed collapses to zero would lock up, so it falls back to the base seed.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int k);
        logic [31:0] s;
        s = base ^ (32'(k) * SEED_MIX);
        return (s == 32'h0) ? base : s;
    endfunction

endpackage

// File: rtl/lfsr_noise_array_if.sv
// lfsr_noise_array_if: control, seed-load and output-stream bundle of the noise array.
//   enable, mode                      : sample request and uniform/Gaussian select
//   seed_valid/seed_ready, seed_ch,
//   seed_data                         : runtime per-lane seed load
//   noise_data/noise_valid/noise_ready,
//   noise_last                        : output stream, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   master drives requests, slave is the noise array.
interface lfsr_noise_array_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4
);
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         enable;
    logic                         mode;
    logic                         seed_valid;
    logic                         seed_ready;
    logic [SW-1:0]                seed_ch;
    logic [31:0]                  seed_data;
    logic [NUM_CH*DATA_WIDTH-1:0] noise_data;
    logic                         noise_valid;
    logic                         noise_ready;
    logic                         noise_last;

    modport master (
        output enable, mode, seed_valid, seed_ch, seed_data, noise_ready,
        input  seed_ready, noise_data, noise_valid, noise_last
    );

    modport slave (
        input  enable, mode, seed_valid, seed_ch, seed_data, noise_ready,
        output seed_ready, noise_data, noise_valid, noise_last
    );

endinterface

// File: rtl/lfsr_noise_array_lfsr32.sv
// lfsr32_galois: one 32-bit right-shift Galois LFSR with step and seed load.
//   clk, rst  : clock, asynchronous active-high reset (loads RESET_VAL)
//   step      : advance one state
//   load      : overwrite with load_data (takes priority over step)
//   load_data : new seed; zero is replaced by ZERO_SUB so the register never locks up
//   q         : current state
module lfsr32_galois
    import noise_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = DEFAULT_SEED,
    parameter logic [31:0] ZERO_SUB  = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_data,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RESET_VAL;
        else if (load) q <= (load_data == 32'h0) ? ZERO_SUB : load_data;
        else if (step) q <= q[0] ? ((q >> 1) ^ LFSR_POLY_MASK) : (q >> 1);
    end

endmodule

// File: rtl/lfsr_noise_array.sv
// lfsr_noise_array: NUM_CH parallel noise lanes, uniform or Irwin-Hall Gaussian, framed valid/ready stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lfsr_noise_array_if.slave (enable/mode, seed load port, noise output stream)
//   Optional macro LFSR_NOISE_GAUSS_EN adds Gaussian mode (accumulators + ACCUM state);
//   without it mode is ignored and every sample is uniform.
module lfsr_noise_array
    import noise_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          NUM_CH     = 4,
    parameter logic [31:0] SEED       = DEFAULT_SEED,
    parameter int          VEC_LEN    = 512,
    parameter int          SUM_TERMS  = 4
) (
    input logic           clk,
    input logic           rst,
    lfsr_noise_array_if.slave bus
);

    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int DW = DATA_WIDTH;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            cnt_nxt;
    logic                     last_nxt;
    logic                     valid_q;
    logic                     last_q;
    logic [NUM_CH*DW-1:0]     data_q;
    logic [NUM_CH*DW-1:0]     uni;
    logic [NUM_CH-1:0][DW-1:0] term;
    logic [31:0]              r [NUM_CH];
    logic                     hs;
    logic                     start;
    logic                     draw;

    assign hs       = valid_q && bus.noise_ready;
    assign start    = bus.enable && (state == IDLE || (state == OUT && hs));
    assign cnt_nxt  = hs ? ((cnt == CW'(VEC_LEN - 1)) ? '0 : cnt + 1'b1) : cnt;
    // The beat counter already includes this edge's handshake when the next sample is loaded.
    assign last_nxt = cnt_nxt == CW'(VEC_LEN - 1);

    assign bus.seed_ready  = state == IDLE;
    assign bus.noise_valid = valid_q;
    assign bus.noise_last  = last_q;
    assign bus.noise_data  = data_q;

`ifdef LFSR_NOISE_GAUSS_EN
    // Sum of four DW-bit terms needs DW+2 bits; subtracting 2*2^DW centres it, >>>2 rescales to DW bits.
    localparam logic [DW+2:0] BIAS = {3'b010, {DW{1'b0}}};

    logic [NUM_CH-1:0][DW+1:0] acc;
    logic [NUM_CH-1:0][DW+1:0] sum;
    logic [NUM_CH*DW-1:0]      gau;
    logic [1:0]                ph;

    assign draw = start || state == ACCUM;
`else
    assign draw = start;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        lfsr32_galois #(
            .RESET_VAL(lane_seed(SEED, k)),
            .ZERO_SUB (SEED)
        ) u_lfsr (
            .clk      (clk),
            .rst      (rst),
            .step     (draw),
            .load     (bus.seed_valid && bus.seed_ready && int'(bus.seed_ch) == k),
            .load_data(bus.seed_data),
            .q        (r[k])
        );
        assign term[k] = r[k][31 -: DW];
        // Flipping the MSB turns offset binary into two's complement.
        assign uni[k*DW +: DW] = {~term[k][DW-1], term[k][DW-2:0]};
`ifdef LFSR_NOISE_GAUSS_EN
        logic [DW+2:0] diff;
        assign sum[k]          = acc[k] + (DW+2)'(term[k]);
        assign diff            = {1'b0, sum[k]} - BIAS;
        assign gau[k*DW +: DW] = DW'($signed(diff) >>> 2);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
`ifdef LFSR_NOISE_GAUSS_EN
            acc     <= '0;
            ph      <= '0;
`endif
        end else begin
            cnt <= cnt_nxt;
`ifdef LFSR_NOISE_GAUSS_EN
            if (start && bus.mode == NOISE_GAUSS) begin
                for (int i = 0; i < NUM_CH; i++) acc[i] <= (DW+2)'(term[i]);
                ph      <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                state   <= ACCUM;
            end else if (state == ACCUM) begin
                acc <= sum;
                ph  <= ph + 2'd1;
                if (ph == 2'(SUM_TERMS - 2)) begin
                    data_q  <= gau;
                    last_q  <= last_nxt;
                    valid_q <= 1'b1;
                    state   <= OUT;
                end
            end else
`endif
            if (start) begin
                data_q  <= uni;
                last_q  <= last_nxt;
                valid_q <= 1'b1;
                state   <= OUT;
            end else if (hs) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_noise_array.sv
// tb_lfsr_noise_array: randomized self-checking bench for lfsr_noise_array against a lane-level draw model.
module tb_lfsr_noise_array;

    localparam int          DW   = 16;
    localparam int          NC   = 3;
    localparam int          VL   = 8;
    localparam logic [31:0] SEED = 32'hACE1_2345;
`ifdef LFSR_NOISE_GAUSS_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_noise_array_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus ();

    lfsr_noise_array #(
        .DATA_WIDTH(DW), .NUM_CH(NC), .SEED(SEED), .VEC_LEN(VL), .SUM_TERMS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int              n_cmp = 0;
    int              n_bad = 0;
    int              bidx;
    logic [31:0]     m [NC];
    logic [NC*DW-1:0] exp_d;
    logic            exp_l;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int k = 0; k < NC; k++) begin
            logic [31:0] t;
            t = SEED ^ (32'(k) * 32'h9E37_79B9);
            m[k] = (t == 32'h0) ? SEED : t;
        end
        bidx = 0;
    endtask

    // Next sample per lane: uniform = term - 2^(DW-1); Gaussian = floor((sum of 4 terms - 2^(DW+1)) / 4).
    task automatic new_sample(input bit g);
        for (int k = 0; k < NC; k++) begin
            int s;
            s = 0;
            for (int j = 0; j < ((g && GEN) ? 4 : 1); j++) begin
                s += int'(m[k] >> (32 - DW));
                m[k] = m[k][0] ? ((m[k] >> 1) ^ 32'h8020_0003) : (m[k] >> 1);
            end
            s = (g && GEN) ? ((s - 2 ** (DW + 1)) >>> 2) : (s - 2 ** (DW - 1));
            exp_d[k*DW +: DW] = s[DW-1:0];
        end
        exp_l = (bidx % VL) == VL - 1;
    endtask

    task automatic do_reset();
        bus.enable = 1'b0; bus.mode = 1'b0; bus.seed_valid = 1'b0;
        bus.seed_ch = '0; bus.seed_data = '0; bus.noise_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.noise_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", bus.noise_valid); end
        n_cmp++; if (bus.noise_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b want=0", bus.noise_last); end
        n_cmp++; if (bus.noise_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h want=0", bus.noise_data); end
        n_cmp++; if (bus.seed_ready !== 1'b1) begin n_bad++; $display("FAIL reset_seed_ready got=%b want=1", bus.seed_ready); end
        do_reset();
    endtask

    task automatic test_uniform_frame();
        do_reset();
        bus.enable = 1'b1; bus.mode = 1'b0; bus.noise_ready = 1'b1;
        tick();
        for (int i = 0; i < 28; i++) begin
            new_sample(1'b0);
            n_cmp++; if (bus.noise_valid !== 1'b1) begin n_bad++; $display("FAIL uni_valid beat=%0d got=%b want=1", i, bus.noise_valid); end
            n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL uni_data beat=%0d got=%h want=%h", i, bus.noise_data, exp_d); end
            n_cmp++; if (bus.noise_last !== exp_l) begin n_bad++; $display("FAIL uni_last beat=%0d got=%b want=%b", i, bus.noise_last, exp_l); end
            if (i == 0) begin
                n_cmp++; if (bus.noise_data[DW-1:0] !== 16'h2CE1) begin n_bad++; $display("FAIL uni_beat0 got=%h want=2ce1", bus.noise_data[DW-1:0]); end
            end
            if (i == 1) begin
                n_cmp++; if (bus.noise_data[DW-1:0] !== 16'h5650) begin n_bad++; $display("FAIL uni_beat1 got=%h want=5650", bus.noise_data[DW-1:0]); end
            end
            if (i == 27) bus.enable = 1'b0;
            tick();
            bidx++;
        end
        n_cmp++; if (bus.noise_valid !== 1'b0) begin n_bad++; $display("FAIL uni_stop got=%b want=0", bus.noise_valid); end
    endtask

    task automatic test_backpressure();
        bus.enable = 1'b1; bus.mode = 1'b0; bus.noise_ready = 1'b0;
        tick();
        new_sample(1'b0);
        n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL bp_first got=%h want=%h", bus.noise_data, exp_d); end
        bus.seed_valid = 1'b1; bus.seed_ch = '0; bus.seed_data = $urandom;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.noise_data !== exp_d || bus.noise_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold cyc=%0d got=%h/%b want=%h/1", i, bus.noise_data, bus.noise_valid, exp_d); end
            n_cmp++; if (bus.seed_ready !== 1'b0) begin n_bad++; $display("FAIL bp_seed_ready got=%b want=0", bus.seed_ready); end
        end
        bus.seed_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic rd;
            rd = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.noise_ready = rd;
            tick();
            if (rd) begin
                bidx++;
                new_sample(1'b0);
            end
            n_cmp++; if (bus.noise_data !== exp_d || bus.noise_valid !== 1'b1) begin n_bad++; $display("FAIL bp_data cyc=%0d got=%h/%b want=%h/1", i, bus.noise_data, bus.noise_valid, exp_d); end
            n_cmp++; if (bus.noise_last !== exp_l) begin n_bad++; $display("FAIL bp_last cyc=%0d got=%b want=%b", i, bus.noise_last, exp_l); end
        end
        bus.noise_ready = 1'b1; bus.enable = 1'b0;
        tick();
        bidx++;
        n_cmp++; if (bus.noise_valid !== 1'b0) begin n_bad++; $display("FAIL bp_stop got=%b want=0", bus.noise_valid); end
    endtask

    task automatic test_mixed_mode();
        bit g;
        int cyc;
        g = 1'($urandom);
        bus.mode = g; bus.enable = 1'b1; bus.noise_ready = 1'b1;
        tick();
        cyc = 1;
        for (int s = 0; s < 30; s++) begin
            while (!bus.noise_valid && cyc < 10) begin
                n_cmp++; if (bus.seed_ready !== 1'b0) begin n_bad++; $display("FAIL mix_seed_ready_accum got=%b want=0", bus.seed_ready); end
                bus.mode = 1'($urandom);
                tick();
                cyc++;
            end
            n_cmp++; if (cyc != ((g && GEN) ? 4 : 1)) begin n_bad++; $display("FAIL mix_latency s=%0d got=%0d want=%0d", s, cyc, (g && GEN) ? 4 : 1); end
            new_sample(g);
            n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL mix_data s=%0d mode=%0d got=%h want=%h", s, g, bus.noise_data, exp_d); end
            n_cmp++; if (bus.noise_last !== exp_l) begin n_bad++; $display("FAIL mix_last s=%0d got=%b want=%b", s, bus.noise_last, exp_l); end
            g = 1'($urandom);
            bus.mode = g;
            if (s == 29) bus.enable = 1'b0;
            tick();
            bidx++;
            cyc = 1;
        end
        n_cmp++; if (bus.noise_valid !== 1'b0) begin n_bad++; $display("FAIL mix_stop got=%b want=0", bus.noise_valid); end
    endtask

`ifdef LFSR_NOISE_GAUSS_EN
    task automatic test_gauss_mean();
        longint acc_sum;
        int cyc;
        acc_sum = 0;
        bus.mode = 1'b1; bus.enable = 1'b1; bus.noise_ready = 1'b1;
        tick();
        for (int s = 0; s < 1200; s++) begin
            cyc = 1;
            while (!bus.noise_valid && cyc < 8) begin tick(); cyc++; end
            new_sample(1'b1);
            n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL gauss_data s=%0d got=%h want=%h", s, bus.noise_data, exp_d); end
            for (int k = 0; k < NC; k++) acc_sum += longint'($signed(bus.noise_data[k*DW +: DW]));
            if (s == 1199) bus.enable = 1'b0;
            tick();
            bidx++;
        end
        n_cmp++; if (acc_sum > 1000 * 1200 * NC || acc_sum < -1000 * 1200 * NC) begin n_bad++; $display("FAIL gauss_mean got_sum=%0d want_abs_mean<=1000", acc_sum); end
    endtask
`endif

    task automatic test_seed();
        logic [31:0] d;
        bus.noise_ready = 1'b1; bus.mode = 1'b0;
        n_cmp++; if (bus.seed_ready !== 1'b1) begin n_bad++; $display("FAIL seed_ready_idle got=%b want=1", bus.seed_ready); end
        bus.seed_valid = 1'b1; bus.seed_ch = 2'd2; bus.seed_data = 32'h0;
        tick();
        bus.seed_valid = 1'b0; m[2] = SEED;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        new_sample(1'b0);
        n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL seed_zero_data got=%h want=%h", bus.noise_data, exp_d); end
        n_cmp++; if (bus.noise_data[2*DW +: DW] !== 16'h2CE1) begin n_bad++; $display("FAIL seed_zero_lane2 got=%h want=2ce1", bus.noise_data[2*DW +: DW]); end
        n_cmp++; if (bus.noise_last !== exp_l) begin n_bad++; $display("FAIL seed_last got=%b want=%b", bus.noise_last, exp_l); end
        tick();
        bidx++;
        bus.seed_valid = 1'b1; bus.seed_ch = 2'd2; bus.seed_data = 32'h1;
        tick();
        bus.seed_valid = 1'b0; m[2] = 32'h1;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        new_sample(1'b0);
        n_cmp++; if (bus.noise_data[2*DW +: DW] !== 16'h8000) begin n_bad++; $display("FAIL seed_one_lane2 got=%h want=8000", bus.noise_data[2*DW +: DW]); end
        n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL seed_one_data got=%h want=%h", bus.noise_data, exp_d); end
        tick();
        bidx++;
        bus.seed_valid = 1'b1; bus.seed_ch = 2'd3; bus.seed_data = $urandom | 32'h1;
        tick();
        bus.seed_valid = 1'b0; bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        new_sample(1'b0);
        n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL seed_out_of_range got=%h want=%h", bus.noise_data, exp_d); end
        tick();
        bidx++;
        d = $urandom;
        bus.seed_valid = 1'b1; bus.seed_ch = 2'd1; bus.seed_data = d; bus.enable = 1'b1;
        tick();
        bus.seed_valid = 1'b0; bus.enable = 1'b0;
        new_sample(1'b0);
        m[1] = (d == 32'h0) ? SEED : d;
        n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL seed_with_draw got=%h want=%h", bus.noise_data, exp_d); end
        tick();
        bidx++;
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
        new_sample(1'b0);
        n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL seed_after_draw got=%h want=%h", bus.noise_data, exp_d); end
        n_cmp++; if (bus.noise_last !== exp_l) begin n_bad++; $display("FAIL seed_frame_kept got=%b want=%b", bus.noise_last, exp_l); end
        tick();
        bidx++;
    endtask

    task automatic test_reset_accum();
        int cyc;
        bus.enable = 1'b1; bus.mode = 1'b1; bus.noise_ready = 1'b0;
        tick();
        bus.enable = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.noise_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got=%b want=0", bus.noise_valid); end
        n_cmp++; if (bus.seed_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle got=%b want=1", bus.seed_ready); end
        n_cmp++; if (bus.noise_data !== '0) begin n_bad++; $display("FAIL rst_mid_data got=%h want=0", bus.noise_data); end
        #1 rst = 1'b0;
        reset_model();
        bus.enable = 1'b1; bus.mode = 1'b1; bus.noise_ready = 1'b1;
        tick();
        bus.enable = 1'b0;
        cyc = 1;
        while (!bus.noise_valid && cyc < 8) begin tick(); cyc++; end
        new_sample(1'b1);
        n_cmp++; if (cyc != (GEN ? 4 : 1)) begin n_bad++; $display("FAIL rst_post_latency got=%0d want=%0d", cyc, GEN ? 4 : 1); end
        n_cmp++; if (bus.noise_data !== exp_d) begin n_bad++; $display("FAIL rst_post_data got=%h want=%h", bus.noise_data, exp_d); end
        n_cmp++; if (bus.noise_last !== exp_l) begin n_bad++; $display("FAIL rst_post_last got=%b want=%b", bus.noise_last, exp_l); end
        tick();
        bidx++;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_uniform_frame();
        test_backpressure();
        test_mixed_mode();
`ifdef LFSR_NOISE_GAUSS_EN
        test_gauss_mean();
`endif
        test_seed();
        test_reset_accum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
